sevenseg_scan_driver: RTL



---
 rtl/sevenseg_pkg.sv | 23 ++
 rtl/sevenseg_decode.sv | 12 +
 rtl/sevenseg_scan_driver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scanner.
// Segment bit 0 is segment a, bit 6 is segment g.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    // Entry n is the segment pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational hex nibble to active-high segment pattern.
// Polarity and blanking are handled by the caller.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex2seg(nibble);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment scanner with a double-buffered display
// word, ghost-suppression blanking and leading-zero suppression.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    enable_i,
    input  logic                    lz_blank_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic [4*NUM_DIGITS-1:0] load_data_i,
    input  logic [NUM_DIGITS-1:0]   load_dp_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   dig_o,
    output logic                    frame_done_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_POL = {7{COMMON_ANODE}};
    localparam logic                  DP_POL  = COMMON_ANODE;
    localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{COMMON_ANODE}};

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  wrap;

    logic [DW-1:0]         active_data_q, active_data_d;
    logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
    logic [DW-1:0]         pend_data_q;
    logic [NUM_DIGITS-1:0] pend_dp_q;
    logic                  pend_full_q;
    logic                  accept;
    logic                  promote;

    logic [NUM_DIGITS-1:0][3:0] nibs;
    logic [NUM_DIGITS-1:0]      zero_from;
    logic [3:0]                 nib_sel;
    logic [6:0]                 seg_dec;
    logic                       lz_hide;
    logic                       lit;
    logic [6:0]                 seg_d;
    logic                       dp_d;
    logic [NUM_DIGITS-1:0]      dig_d;

    // Scan sequencing; the counter spans the whole slot, blank then lit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap    = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ON;
                    end
                end
                ON: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign load_ready_o = !pend_full_q;
    assign accept       = load_valid_i && !pend_full_q;
    assign promote      = pend_full_q && (frame_done_o || state_q == IDLE);

    assign active_data_d = promote ? pend_data_q : active_data_q;
    assign active_dp_d   = promote ? pend_dp_q : active_dp_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_full_q   <= 1'b0;
            active_data_q <= '0;
            active_dp_q   <= '0;
        end else begin
            active_data_q <= active_data_d;
            active_dp_q   <= active_dp_d;
            if (accept) begin
                pend_data_q <= load_data_i;
                pend_dp_q   <= load_dp_i;
                pend_full_q <= 1'b1;
            end else if (promote) begin
                pend_full_q <= 1'b0;
            end
        end
    end

    // Output stage looks one cycle ahead so the pads track the state register.
    assign nibs    = active_data_d;
    assign nib_sel = nibs[idx_d];

    sevenseg_decode u_decode (
        .nibble (nib_sel),
        .seg    (seg_dec)
    );

    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (nibs[NUM_DIGITS-1] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (nibs[i] == 4'h0);
        end
    end

    assign lz_hide = lz_blank_i && (idx_d != '0) && zero_from[idx_d];
    assign lit     = (state_d == ON);
    assign seg_d   = (lit && !lz_hide) ? seg_dec : 7'h00;
    assign dp_d    = lit && active_dp_d[idx_d];
    assign dig_d   = lit ? (NUM_DIGITS'(1) << idx_d) : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            seg_o        <= SEG_POL;
            dp_o         <= DP_POL;
            dig_o        <= DIG_POL;
            frame_done_o <= 1'b0;
        end else begin
            seg_o        <= seg_d ^ SEG_POL;
            dp_o         <= dp_d ^ DP_POL;
            dig_o        <= dig_d ^ DIG_POL;
            frame_done_o <= wrap;
        end
    end

endmodule
